m_matrix_key_emu: RTL and testbench

//  Keypad emulator: the row-driving end of the 4x4 matrix-key interface that m_matrix_key scans.

---
 rtl/m_matrix_key_emu.sv | 127 ++++++++++++
 tb/tb_m_matrix_key_emu.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_matrix_key_emu.sv
// Keypad emulator: presents one calculator key on the row returns of a 4x4 matrix-key scanner,
// holding it for HOLD_SCANS complete column scans and then releasing it for REL_SCANS scans.
module m_matrix_key_emu #(
    parameter int HOLD_SCANS  = 3,
    parameter int REL_SCANS   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    input  logic [3:0]  code,
    input  logic        code_valid,
    output logic        code_ready,
    output logic        busy,
    output logic [15:0] key_bmp,
    output logic        done,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [7:0]    HOLD_LAST = 8'(HOLD_SCANS);
    localparam logic [7:0]    REL_LAST  = 8'(REL_SCANS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

    state_t        state;
    logic [3:0]    col_q;
    logic [7:0]    scan_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          scan_start;

    // Inverse of the calculator decoder: bitmap bit index is row*4 + column.
    function automatic logic [15:0] code_to_bmp(input logic [3:0] c);
        logic [3:0] idx;
        idx = '0;
        case (c)
            4'h1: idx = 4'd0;
            4'h2: idx = 4'd1;
            4'h3: idx = 4'd2;
            4'hA: idx = 4'd3;
            4'h4: idx = 4'd4;
            4'h5: idx = 4'd5;
            4'h6: idx = 4'd6;
            4'hB: idx = 4'd7;
            4'h7: idx = 4'd8;
            4'h8: idx = 4'd9;
            4'h9: idx = 4'd10;
            4'hC: idx = 4'd11;
            4'hE: idx = 4'd12;
            4'h0: idx = 4'd13;
            4'hF: idx = 4'd14;
            4'hD: idx = 4'd15;
            default: idx = '0;
        endcase
        return 16'h0001 << idx;
    endfunction

    always_comb begin
        row = '1;
        for (int unsigned r = 0; r < 4; r++) begin
            row[r] = ~|(key_bmp[r*4 +: 4] & ~col);
        end
    end

    assign scan_start = (col == 4'b1110) && (col_q != 4'b1110);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            key_bmp    <= '0;
            code_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            col_q      <= '1;
            scan_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            col_q <= col;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (code_valid && code_ready) begin
                        key_bmp    <= code_to_bmp(code);
                        scan_cnt   <= '0;
                        tmo_cnt    <= '0;
                        code_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= PRESS;
                    end else begin
                        code_ready <= 1'b1;
                    end
                end
                PRESS, RELEASE: begin
                    // A scan start always beats a simultaneous timeout.
                    if (scan_start) begin
                        tmo_cnt <= '0;
                        if (state == PRESS && scan_cnt == HOLD_LAST) begin
                            key_bmp  <= '0;
                            scan_cnt <= '0;
                            state    <= RELEASE;
                        end else if (state == RELEASE && scan_cnt == REL_LAST) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            scan_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            scan_cnt <= scan_cnt + 8'd1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err      <= 1'b1;
                        key_bmp  <= '0;
                        busy     <= 1'b0;
                        scan_cnt <= '0;
                        tmo_cnt  <= '0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_matrix_key_emu.sv
// Bench for m_matrix_key_emu: a behavioural column scanner reconstructs pressed keys and checks
// them against a scoreboard of sent codes; directed tasks cover reset, row logic, handshake, timeout.
module tb_m_matrix_key_emu;
    localparam int HOLD   = 3;
    localparam int REL    = 2;
    localparam int TMO    = 64;
    localparam int PH_LEN = 2;
    localparam int SCAN   = 4 * PH_LEN;
    localparam int LAT_LO = (HOLD + REL) * SCAN + 2;
    localparam int LAT_HI = (HOLD + REL + 1) * SCAN + 1;
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  code = 4'h0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic        busy;
    logic [15:0] key_bmp;
    logic        done;
    logic        err;

    logic [3:0]  man_col = 4'b1110;
    logic        scan_en = 1'b0;
    logic [1:0]  ph = 2'd0;
    int          ph_cnt = 0;

    int vectors = 0;
    int miscompares = 0;
    int n_decoded = 0;

    logic [15:0] exp_bmp_q[$];
    logic [3:0]  exp_code_q[$];

    int idx_of[16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11, 15, 12, 14};

    assign col = scan_en ? ~(4'b0001 << ph) : man_col;

    m_matrix_key_emu #(
        .HOLD_SCANS (HOLD),
        .REL_SCANS  (REL),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .code      (code),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .busy      (busy),
        .key_bmp   (key_bmp),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bmp_of(input logic [3:0] c);
        return 16'h0001 << idx_of[c];
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard on the bitmap: each rising key_bmp must match the next sent code.
    initial begin : bmp_monitor
        logic [15:0] prev;
        logic [15:0] exp_b;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst && key_bmp !== 16'h0 && prev === 16'h0) begin
                vectors++;
                if (exp_bmp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL key_bmp_unexpected: got %h, expected no press", key_bmp);
                end else begin
                    exp_b = exp_bmp_q.pop_front();
                    if (key_bmp !== exp_b) begin
                        miscompares++;
                        $display("FAIL key_bmp: got %h, want %h", key_bmp, exp_b);
                    end
                end
            end
            prev = key_bmp;
        end
    end

    // Column scanner: samples rows at the end of each phase, decodes one full scan at a time.
    initial begin : scanner
        logic [15:0] acc;
        logic        prev_nz;
        int          run;
        logic [3:0]  exp_c;
        acc = '0;
        prev_nz = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (!scan_en) begin
                ph = 2'd0;
                ph_cnt = 0;
                acc = '0;
                prev_nz = 1'b0;
                run = 0;
            end else if (ph_cnt < PH_LEN - 1) begin
                ph_cnt++;
            end else begin
                for (int r = 0; r < 4; r++) begin
                    if (row[r] === 1'b0) acc[4 * r + int'(ph)] = 1'b1;
                end
                if (ph == 2'd3) begin
                    if (acc != 16'h0) begin
                        if (!prev_nz) begin
                            vectors++;
                            n_decoded++;
                            if (exp_code_q.size() == 0) begin
                                miscompares++;
                                $display("FAIL scan_decode: got bitmap %h, expected no press", acc);
                            end else begin
                                exp_c = exp_code_q.pop_front();
                                if (acc !== bmp_of(exp_c)) begin
                                    miscompares++;
                                    $display("FAIL scan_decode_%h: got %h, want %h", exp_c, acc, bmp_of(exp_c));
                                end
                            end
                            run = 0;
                        end
                        run++;
                    end else if (prev_nz) begin
                        vectors++;
                        if (run < HOLD || run > HOLD + 1) begin
                            miscompares++;
                            $display("FAIL scan_hold: got %0d scans, want %0d..%0d", run, HOLD, HOLD + 1);
                        end
                    end
                    prev_nz = (acc != 16'h0);
                    acc = '0;
                end
                ph_cnt = 0;
                ph = ph + 2'd1;
            end
        end
    end

    // Offer a code and return 1 ns after the accepting edge.
    task automatic send_code(input logic [3:0] c, input bit keep);
        int n;
        @(negedge clk);
        code = c;
        code_valid = 1'b1;
        exp_bmp_q.push_back(bmp_of(c));
        if (scan_en) exp_code_q.push_back(c);
        n = 0;
        while (!code_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!code_ready) begin
            miscompares++;
            $display("FAIL accept_%h: code_ready got 0 after %0d cycles, want 1", c, n);
            code_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!keep) code_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        man_col = 4'b1110;
        repeat (3) @(negedge clk);
        vectors++;
        if (row !== 4'hF) begin miscompares++; $display("FAIL reset_row: got %b, want 1111", row); end
        vectors++;
        if (code_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, want 1", code_ready); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, want 0", busy); end
        vectors++;
        if (key_bmp !== 16'h0) begin miscompares++; $display("FAIL reset_bmp: got %h, want 0000", key_bmp); end
        vectors++;
        if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b, want 00", {done, err}); end
        rst = 1'b1;
        man_col = 4'hF;
        @(negedge clk);
        send_code(4'h5, 1'b0);
        @(negedge clk);
        man_col = 4'b1101;
        #1;
        vectors++;
        if (row !== 4'b1101) begin miscompares++; $display("FAIL press_row: got %b, want 1101", row); end
        rst = 1'b0;
        #1;
        vectors++;
        if (row !== 4'hF) begin miscompares++; $display("FAIL reset_mid_press_row: got %b, want 1111", row); end
        vectors++;
        if (key_bmp !== 16'h0) begin miscompares++; $display("FAIL reset_mid_press_bmp: got %h, want 0000", key_bmp); end
        @(negedge clk);
        rst = 1'b1;
        man_col = 4'hF;
        @(negedge clk);
    endtask

    task automatic test_row_logic;
        int n;
        man_col = 4'hF;
        send_code(4'h9, 1'b0);
        vectors++;
        if (key_bmp !== 16'h0400) begin miscompares++; $display("FAIL row_bmp: got %h, want 0400", key_bmp); end
        man_col = 4'b1011;
        #1;
        vectors++;
        if (row !== 4'b1011) begin miscompares++; $display("FAIL row_col2: got %b, want 1011", row); end
        man_col = 4'b1101;
        #1;
        vectors++;
        if (row !== 4'hF) begin miscompares++; $display("FAIL row_col1: got %b, want 1111", row); end
        man_col = 4'b0000;
        #1;
        vectors++;
        if (row !== 4'b1011) begin miscompares++; $display("FAIL row_all_cols: got %b, want 1011", row); end
        man_col = 4'hF;
        n = 0;
        while (!err && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL row_abort: err got %b, want 1", err); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        int dn;
        man_col = 4'hF;
        send_code(4'h1, 1'b0);
        n = 0;
        dn = 0;
        while (!err && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (done) dn++;
        end
        vectors++;
        if (n != TMO + 1) begin miscompares++; $display("FAIL tmo_latency: got %0d, want %0d", n, TMO + 1); end
        vectors++;
        if (key_bmp !== 16'h0 || row !== 4'hF) begin
            miscompares++;
            $display("FAIL tmo_release: got bmp %h row %b, want 0000 1111", key_bmp, row);
        end
        vectors++;
        if (busy !== 1'b0 || code_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_state: got busy %b ready %b, want 0 0", busy, code_ready);
        end
        vectors++;
        if (dn != 0) begin miscompares++; $display("FAIL tmo_no_done: got %0d done pulses, want 0", dn); end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0 || code_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_after: got err %b ready %b, want 0 1", err, code_ready);
        end
    endtask

    task automatic test_scan_press;
        int n;
        man_col = 4'hF;
        scan_en = 1'b1;
        send_code(4'h5, 1'b0);
        vectors++;
        if (key_bmp !== 16'h0020) begin miscompares++; $display("FAIL press5_bmp: got %h, want 0020", key_bmp); end
        vectors++;
        if ({busy, code_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL press5_hs: got busy/ready %b, want 10", {busy, code_ready});
        end
        wait_done(n);
        vectors++;
        if (done !== 1'b1 || n < LAT_LO || n > LAT_HI) begin
            miscompares++;
            $display("FAIL press5_latency: got %0d cycles done %b, want %0d..%0d", n, done, LAT_LO, LAT_HI);
        end
        vectors++;
        if (code_ready !== 1'b0 || key_bmp !== 16'h0) begin
            miscompares++;
            $display("FAIL press5_done_cycle: got ready %b bmp %h, want 0 0000", code_ready, key_bmp);
        end
        @(negedge clk);
        vectors++;
        if (code_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL press5_after: got ready %b done %b, want 1 0", code_ready, done);
        end
        scan_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_handshake;
        int n;
        int viol;
        man_col = 4'hF;
        scan_en = 1'b1;
        send_code(4'h2, 1'b1);
        code = 4'h7;
        exp_bmp_q.push_back(bmp_of(4'h7));
        exp_code_q.push_back(4'h7);
        n = 0;
        viol = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (code_ready !== 1'b0 || busy !== 1'b1) viol++;
            if (key_bmp !== 16'h0 && key_bmp !== bmp_of(4'h2)) viol++;
        end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL hs_done: got %b, want 1", done); end
        vectors++;
        if (viol != 0) begin miscompares++; $display("FAIL hs_busy_period: got %0d violations, want 0", viol); end
        vectors++;
        if (code_ready !== 1'b0) begin miscompares++; $display("FAIL hs_ready_at_done: got %b, want 0", code_ready); end
        @(negedge clk);
        vectors++;
        if (code_ready !== 1'b1 || key_bmp !== 16'h0) begin
            miscompares++;
            $display("FAIL hs_idle: got ready %b bmp %h, want 1 0000", code_ready, key_bmp);
        end
        @(negedge clk);
        code_valid = 1'b0;
        vectors++;
        if (key_bmp !== 16'h0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_capture7: got bmp %h busy %b, want 0100 1", key_bmp, busy);
        end
        wait_done(n);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL hs_done7: got %b, want 1", done); end
        scan_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        int dec0;
        man_col = 4'hF;
        scan_en = 1'b1;
        dec0 = n_decoded;
        for (int c = 0; c < 16; c++) begin
            send_code(4'(c), c != 15);
            if (c == 0) begin
                vectors++;
                if (key_bmp !== 16'h2000) begin miscompares++; $display("FAIL b2b_code0: got %h, want 2000", key_bmp); end
            end
            if (c == 13) begin
                vectors++;
                if (key_bmp !== 16'h8000) begin miscompares++; $display("FAIL b2b_codeD: got %h, want 8000", key_bmp); end
            end
        end
        wait_done(n);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_last_done: got %b, want 1", done); end
        repeat (2) @(negedge clk);
        scan_en = 1'b0;
        vectors++;
        if (n_decoded - dec0 != 16) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d decoded, want 16", n_decoded - dec0);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_row_logic;
        test_timeout;
        test_scan_press;
        test_handshake;
        test_back_to_back;
        vectors++;
        if (exp_bmp_q.size() != 0 || exp_code_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d/%0d left, want 0/0", exp_bmp_q.size(), exp_code_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
